ascii_seg_display: RTL

//  Downstream stage of the anthem character source. Accepts ASCII bytes over a valid/ready handshake
//  and buffers them in a small FIFO. Shows each byte as a 7-segment pattern on the dedicated outputs
//  for a fixed dwell time, so a stream of characters scrolls one at a time on the board display.

---
 rtl/seg_disp_pkg.sv | 60 ++++++
 rtl/char_fifo.sv | 54 +++++
 rtl/ascii_seg_display.sv | 131 +++++++++++++
 3 files changed

// File: rtl/seg_disp_pkg.sv
// seg_disp_pkg: shared state encoding, segment constants and ASCII-to-7-segment decode. Rev 1.0
`default_nettype none

package seg_disp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [7:0] SEG_BLANK    = 8'h00;
  localparam logic [7:0] SEG_UNMAPPED = 8'h80;

  // Segment order {dp,g,f,e,d,c,b,a}; lower-case letters fold onto the same glyphs.
  function automatic logic [7:0] ascii_to_seg(input logic [7:0] ch);
    logic [7:0] up;
    logic [7:0] seg;
    up = ((ch >= 8'h61) && (ch <= 8'h7A)) ? (ch - 8'h20) : ch;
    case (up)
      8'h30: seg = 8'h3F;
      8'h31: seg = 8'h06;
      8'h32: seg = 8'h5B;
      8'h33: seg = 8'h4F;
      8'h34: seg = 8'h66;
      8'h35: seg = 8'h6D;
      8'h36: seg = 8'h7D;
      8'h37: seg = 8'h07;
      8'h38: seg = 8'h7F;
      8'h39: seg = 8'h6F;
      8'h41: seg = 8'h77;
      8'h42: seg = 8'h7C;
      8'h43: seg = 8'h39;
      8'h44: seg = 8'h5E;
      8'h45: seg = 8'h79;
      8'h46: seg = 8'h71;
      8'h47: seg = 8'h3D;
      8'h48: seg = 8'h76;
      8'h49: seg = 8'h30;
      8'h4A: seg = 8'h1E;
      8'h4C: seg = 8'h38;
      8'h4E: seg = 8'h54;
      8'h4F: seg = 8'h3F;
      8'h50: seg = 8'h73;
      8'h52: seg = 8'h50;
      8'h53: seg = 8'h6D;
      8'h54: seg = 8'h78;
      8'h55: seg = 8'h3E;
      8'h59: seg = 8'h6E;
      8'h20: seg = SEG_BLANK;
      8'h2D: seg = 8'h40;
      8'h5F: seg = 8'h08;
      default: seg = SEG_UNMAPPED;
    endcase
    return seg;
  endfunction

endpackage

`default_nettype wire

// File: rtl/char_fifo.sv
// char_fifo: small power-of-two FIFO with extra-MSB pointers and a registered ready (= not full). Rev 1.0
`default_nettype none

module char_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic             ready
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr, wr_ptr_nx, rd_ptr_nx;
  logic             do_push, do_pop, full_nx;

  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign wr_ptr_nx = wr_ptr + {{AW{1'b0}}, do_push};
  assign rd_ptr_nx = rd_ptr + {{AW{1'b0}}, do_pop};

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign full_nx = (wr_ptr_nx[AW] != rd_ptr_nx[AW]) && (wr_ptr_nx[AW-1:0] == rd_ptr_nx[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // ready looks at post-edge occupancy so it is never one cycle stale after a fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ready  <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr_nx;
      rd_ptr <= rd_ptr_nx;
      ready  <= !full_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

`default_nettype wire

// File: rtl/ascii_seg_display.sv
// ascii_seg_display: buffers ASCII bytes and shows each on a 7-segment display for a fixed dwell.
// Optional macro GAP_BLANK_EN inserts a blank gap between characters. Rev 1.0
`default_nettype none

module ascii_seg_display
  import seg_disp_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int HOLD_CYCLES = 1000,
  parameter int GAP_CYCLES  = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ch_data,
  input  logic       ch_valid,
  output logic       ch_ready,
  output logic [7:0] seg_out,
  output logic       busy
);

  localparam int TMAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES - 1);
`ifdef GAP_BLANK_EN
  localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_CYCLES - 1);
`endif

  state_t        state_q, state_nx;
  logic [TW-1:0] timer_q, timer_nx;
  logic [7:0]    seg_q, seg_nx;
  logic [7:0]    head;
  logic          push, pop, full, empty;

  assign push = ch_valid && ch_ready;

  char_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .wr_data (ch_data),
    .pop     (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .ready   (ch_ready)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      seg_q   <= SEG_BLANK;
    end else begin
      state_q <= state_nx;
      timer_q <= timer_nx;
      seg_q   <= seg_nx;
    end
  end

  always_comb begin
    state_nx = state_q;
    timer_nx = timer_q;
    seg_nx   = seg_q;
    pop      = 1'b0;
    case (state_q)
      IDLE: begin
        seg_nx = SEG_BLANK;
        if (!empty) begin
          pop      = 1'b1;
          seg_nx   = ascii_to_seg(head);
          timer_nx = HOLD_LOAD;
          state_nx = SHOW;
        end
      end
      SHOW: begin
        if (ena) begin
          if (timer_q != '0) begin
            timer_nx = timer_q - 1'b1;
          end else begin
`ifdef GAP_BLANK_EN
            seg_nx   = SEG_BLANK;
            timer_nx = GAP_LOAD;
            state_nx = GAP;
`else
            if (!empty) begin
              pop      = 1'b1;
              seg_nx   = ascii_to_seg(head);
              timer_nx = HOLD_LOAD;
            end else begin
              seg_nx   = SEG_BLANK;
              state_nx = IDLE;
            end
`endif
          end
        end
      end
`ifdef GAP_BLANK_EN
      GAP: begin
        if (ena) begin
          if (timer_q != '0) begin
            timer_nx = timer_q - 1'b1;
          end else if (!empty) begin
            pop      = 1'b1;
            seg_nx   = ascii_to_seg(head);
            timer_nx = HOLD_LOAD;
            state_nx = SHOW;
          end else begin
            state_nx = IDLE;
          end
        end
      end
`endif
      default: begin
        seg_nx   = SEG_BLANK;
        state_nx = IDLE;
      end
    endcase
  end

  always_comb begin
    seg_out = seg_q;
    busy    = (state_q != IDLE) || !empty;
  end

endmodule

`default_nettype wire
